// File: rtl/cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache controller with a req/ack memory port
// and a saturating read-hit counter. Tag/valid/data storage is held in flops.
module cache_ctrl #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int INDEX_W = 2,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    input  logic              flush,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [CNT_W-1:0]  hit_cnt
);
    localparam int LINES = 1 << INDEX_W;
    localparam int TAG_W = ADDR_W - INDEX_W;

    typedef enum logic [1:0] {IDLE, LOOKUP, MISS_RD, WR_THRU} state_t;

    state_t             state_q, state_d;
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [LINES-1:0]   valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q [LINES];
    logic [TAG_W-1:0]   tag_d [LINES];
    logic [DATA_W-1:0]  data_q [LINES];
    logic [DATA_W-1:0]  data_d [LINES];
    logic [DATA_W-1:0]  cpu_rdata_q, cpu_rdata_d;
    logic               cpu_ready_q, cpu_ready_d;
    logic               mem_req_q, mem_req_d;
    logic               mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
    logic [CNT_W-1:0]   hit_cnt_q, hit_cnt_d;

    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   tag;
    logic               hit;

    assign idx = addr_q[INDEX_W-1:0];
    assign tag = addr_q[ADDR_W-1:INDEX_W];
    assign hit = valid_q[idx] && (tag_q[idx] == tag);

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        valid_d     = valid_q;
        tag_d       = tag_q;
        data_d      = data_q;
        cpu_rdata_d = cpu_rdata_q;
        cpu_ready_d = 1'b0;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        hit_cnt_d   = hit_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (flush) begin
                    valid_d = '0;
                end else if (cpu_req) begin
                    we_d    = cpu_we;
                    addr_d  = cpu_addr;
                    wdata_d = cpu_wdata;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (!we_q && hit) begin
                    cpu_rdata_d = data_q[idx];
                    cpu_ready_d = 1'b1;
                    if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + CNT_W'(1);
                    state_d = IDLE;
                end else if (!we_q) begin
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = addr_q;
                    state_d    = MISS_RD;
                end else begin
                    // Write-through: a hit refreshes the line, a miss leaves the cache untouched.
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = addr_q;
                    mem_wdata_d = wdata_q;
                    if (hit) data_d[idx] = wdata_q;
                    state_d = WR_THRU;
                end
            end
            MISS_RD: begin
                if (mem_ack) begin
                    data_d[idx]  = mem_rdata;
                    tag_d[idx]   = tag;
                    valid_d[idx] = 1'b1;
                    cpu_rdata_d  = mem_rdata;
                    cpu_ready_d  = 1'b1;
                    mem_req_d    = 1'b0;
                    state_d      = IDLE;
                end
            end
            WR_THRU: begin
                if (mem_ack) begin
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    cpu_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            valid_q     <= '0;
            cpu_rdata_q <= '0;
            cpu_ready_q <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            hit_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            valid_q     <= valid_d;
            cpu_rdata_q <= cpu_rdata_d;
            cpu_ready_q <= cpu_ready_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            hit_cnt_q   <= hit_cnt_d;
        end
    end

    // Tag/data contents are meaningless while their valid bit is clear, so they carry no reset.
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

    assign cpu_rdata = cpu_rdata_q;
    assign cpu_ready = cpu_ready_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign hit_cnt   = hit_cnt_q;

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl: a line-level cache/memory model drives per-cycle expectations
// that one negedge process compares against the DUT, plus literal checks from the test plan.
module tb_cache_ctrl;
    localparam int CW = 3;
    localparam logic [CW-1:0] HMAX = '1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       cpu_req = 1'b0, cpu_we = 1'b0, flush = 1'b0, mem_ack = 1'b0;
    logic [7:0] cpu_addr = '0, cpu_wdata = '0, mem_rdata = '0;
    logic [7:0] cpu_rdata, mem_addr, mem_wdata;
    logic       cpu_ready, mem_req, mem_we;
    logic [CW-1:0] hit_cnt;

    cache_ctrl #(.ADDR_W(8), .DATA_W(8), .INDEX_W(2), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .flush(flush),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .hit_cnt(hit_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Model state: cache lines, backing memory, and expected output values for the current cycle
    bit         mv [4];
    logic [5:0] mt [4];
    logic [7:0] md [4];
    logic [7:0] memv [256];
    bit         chk_en = 1'b0;
    logic       exp_ready = 1'b0, exp_mem_req = 1'b0, exp_mem_we = 1'b0;
    logic [7:0] exp_rdata = '0, exp_mem_addr = '0, exp_mem_wdata = '0;
    logic [CW-1:0] exp_hits = '0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cpu_ready", 32'(cpu_ready), 32'(exp_ready));
            if (exp_ready) chk("cpu_rdata", 32'(cpu_rdata), 32'(exp_rdata));
            chk("mem_req", 32'(mem_req), 32'(exp_mem_req));
            if (exp_mem_req) begin
                chk("mem_we", 32'(mem_we), 32'(exp_mem_we));
                chk("mem_addr", 32'(mem_addr), 32'(exp_mem_addr));
                if (exp_mem_we) chk("mem_wdata", 32'(mem_wdata), 32'(exp_mem_wdata));
            end
            chk("hit_cnt", 32'(hit_cnt), 32'(exp_hits));
        end
    end

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) mv[i] = 1'b0;
        exp_ready = 1'b0; exp_mem_req = 1'b0; exp_mem_we = 1'b0;
        exp_rdata = '0; exp_hits = '0;
    endfunction

    // One CPU transaction, entered and left at posedge+1 with the controller idle.
    task automatic op(input bit we, input logic [7:0] a, input logic [7:0] wd, input int dly,
                      output logic [7:0] rd, output bit sm);
        int idx;
        bit hit;
        idx = int'(a[1:0]);
        hit = mv[idx] && (mt[idx] == a[7:2]);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
        @(posedge clk); #1;
        cpu_req = 1'b0; cpu_we = ~we; cpu_addr = ~a; cpu_wdata = ~wd;
        @(posedge clk); #1;
        sm = mem_req;
        if (!we && hit) begin
            exp_rdata = md[idx];
            exp_ready = 1'b1;
            if (exp_hits != HMAX) exp_hits++;
        end else begin
            exp_mem_req = 1'b1; exp_mem_we = we; exp_mem_addr = a;
            if (we) begin
                exp_mem_wdata = wd;
                if (hit) md[idx] = wd;
            end
            for (int i = 1; i < dly; i++) begin @(posedge clk); #1; end
            mem_ack = 1'b1;
            mem_rdata = we ? 8'h00 : memv[a];
            @(posedge clk); #1;
            mem_ack = 1'b0; mem_rdata = 8'hEE;
            exp_mem_req = 1'b0; exp_mem_we = 1'b0; exp_ready = 1'b1;
            if (we) memv[a] = wd;
            else begin
                exp_rdata = memv[a]; md[idx] = memv[a]; mt[idx] = a[7:2]; mv[idx] = 1'b1;
            end
        end
        rd = cpu_rdata;
        @(posedge clk); #1;
        exp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rd;
        bit sm;
        for (int i = 0; i < 256; i++) memv[i] = 8'(i) ^ 8'hC3;
        memv[8'h15] = 8'hA5;
        memv[8'h55] = 8'h77;
        model_reset();
        #1 rst_n = 1'b0;
        #2 chk_en = 1'b1;
        chk("rst_mem_addr", 32'(mem_addr), 32'h0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'h0);
        chk("rst_cpu_rdata", 32'(cpu_rdata), 32'h0);
        chk("rst_mem_we", 32'(mem_we), 32'h0);
        @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        op(1'b0, 8'h15, 8'h00, 3, rd, sm);
        chk("t1_rdata", 32'(rd), 32'hA5); chk("t1_mem", 32'(sm), 1); chk("t1_hits", 32'(hit_cnt), 0);
        op(1'b0, 8'h15, 8'h00, 1, rd, sm);
        chk("t2_rdata", 32'(rd), 32'hA5); chk("t2_mem", 32'(sm), 0); chk("t2_hits", 32'(hit_cnt), 1);
        op(1'b1, 8'h15, 8'h3C, 1, rd, sm);
        chk("t3_wr_mem", 32'(sm), 1);
        op(1'b0, 8'h15, 8'h00, 1, rd, sm);
        chk("t3_rdata", 32'(rd), 32'h3C); chk("t3_mem", 32'(sm), 0);
        op(1'b0, 8'h55, 8'h00, 2, rd, sm);
        chk("t4_rdata", 32'(rd), 32'h77); chk("t4_mem", 32'(sm), 1);
        op(1'b0, 8'h15, 8'h00, 1, rd, sm);
        chk("t4_refill_rdata", 32'(rd), 32'h3C); chk("t4_refill_mem", 32'(sm), 1);
        op(1'b1, 8'h02, 8'h9E, 2, rd, sm);
        op(1'b0, 8'h02, 8'h00, 1, rd, sm);
        chk("t5_rdata", 32'(rd), 32'h9E); chk("t5_mem", 32'(sm), 1);

        for (int i = 0; i < 8; i++) op(1'b0, 8'h15, 8'h00, 1, rd, sm);
        chk("sat_hits", 32'(hit_cnt), 32'h7);

        // Flush wins over a simultaneous request: nothing should start.
        flush = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h15;
        @(posedge clk); #1;
        flush = 1'b0; cpu_req = 1'b0;
        for (int i = 0; i < 4; i++) mv[i] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        op(1'b0, 8'h15, 8'h00, 1, rd, sm);
        chk("t6_flush_mem", 32'(sm), 1); chk("t6_rdata", 32'(rd), 32'h3C);

        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h33;
        @(posedge clk); #1;
        cpu_req = 1'b0;
        @(posedge clk); #1;
        exp_mem_req = 1'b1; exp_mem_we = 1'b0; exp_mem_addr = 8'h33;
        @(posedge clk); #1;
        #1 rst_n = 1'b0;
        #1 chk("t7_rst_mem_req", 32'(mem_req), 0);
        model_reset();
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        mem_ack = 1'b1; mem_rdata = 8'h55;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        chk("t7_no_ready", 32'(cpu_ready), 0);
        op(1'b0, 8'h33, 8'h00, 1, rd, sm);
        chk("t7_rdata", 32'(rd), 32'hF0); chk("t7_mem", 32'(sm), 1); chk("t7_hits", 32'(hit_cnt), 0);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cache_ctrl.md
Name: cache_ctrl

Overview:
- Direct-mapped, write-through, no-write-allocate cache controller.
- Sequences the cache tag/valid/data storage (register flops) between a single CPU port and a slow memory port with a req/ack handshake.
- Sits between the CPU load/store unit and main memory.
- Keeps a saturating hit counter for performance checks.

Parameters:
- ADDR_W, 8, CPU/memory word address width.
- DATA_W, 8, data word width; one word per cache line.
- INDEX_W, 2, index bits; 2**INDEX_W lines; tag width = ADDR_W-INDEX_W.
- CNT_W, 16, hit counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU request; sampled only in IDLE.
- cpu_we  in  1  1=write, 0=read.
- cpu_addr  in  ADDR_W  word address.
- cpu_wdata  in  DATA_W  write data.
- cpu_rdata  out  DATA_W  read data; valid when cpu_ready=1.
- cpu_ready  out  1  one-cycle completion pulse.
- flush  in  1  invalidate all lines; sampled only in IDLE.
- mem_req  out  1  memory request; held until mem_ack.
- mem_we  out  1  memory write strobe.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; valid with mem_ack.
- mem_ack  in  1  memory completion, one cycle.
- hit_cnt  out  CNT_W  saturating count of read hits.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all valid bits, cpu_ready, cpu_rdata, mem_req, mem_we, mem_addr, mem_wdata and hit_cnt cleared to 0. Tag/data contents are don't-care.
- Reset mid-transaction drops mem_req immediately and discards the transaction.
- States: IDLE, LOOKUP, MISS_RD, WR_THRU.
- IDLE:
  - flush=1: clear all valid bits in one cycle and stay in IDLE. No cpu_ready. flush has priority over cpu_req.
  - else cpu_req=1: latch cpu_we, cpu_addr and cpu_wdata; go to LOOKUP.
- LOOKUP (1 cycle): hit = valid[idx] && tag[idx]==addr tag.
  - Read hit: cpu_rdata<=data[idx]; cpu_ready=1 next cycle; hit_cnt+1 (saturates at all-ones); go to IDLE. Latency: req accepted at edge N, cpu_ready high in cycle N+2.
  - Read miss: mem_req=1, mem_we=0, mem_addr=latched addr; go to MISS_RD.
  - Write: mem_req=1, mem_we=1, mem_addr/mem_wdata=latched values. On a write hit, data[idx] is updated now. A write miss does not allocate. Go to WR_THRU.
- MISS_RD:
  - Hold mem_req/mem_addr stable until mem_ack.
  - On mem_ack: data[idx]<=mem_rdata, tag[idx]<=addr tag, valid[idx]<=1, cpu_rdata<=mem_rdata, cpu_ready pulse, mem_req<=0; go to IDLE.
- WR_THRU:
  - Hold outputs until mem_ack.
  - On mem_ack: mem_req<=0, mem_we<=0, cpu_ready pulse; go to IDLE. cpu_rdata is unchanged.
- Outside MISS_RD and WR_THRU, mem_ack is ignored. Outside IDLE, cpu_req and flush are ignored; the CPU must wait for cpu_ready.
- A cpu_req asserted in the cycle cpu_ready is high is accepted at the next edge, since the controller is then in IDLE. Back-to-back throughput is one read hit per 2 cycles.
- All outputs are registered. mem_ack may arrive the cycle after mem_req rises, or any number of cycles later.
- Index and tag wrap naturally with address bits; there is no address range check.

Test Plan:
- Reset, then read addr 0x15 with memory returning 0xA5 after 3 cycles -> mem_req high with mem_addr=0x15 and mem_we=0; cpu_rdata=0xA5 with one-cycle cpu_ready; hit_cnt=0.
- Read 0x15 again -> no mem_req; cpu_ready 2 cycles after accept; cpu_rdata=0xA5; hit_cnt=1.
- Write 0x15=0x3C (hit) with mem_ack after 1 cycle, then read 0x15 -> mem_we=1, mem_wdata=0x3C; the following read hits and returns 0x3C.
- Read 0x55 (same index, different tag) with memory returning 0x77 -> miss and refill; a subsequent read of 0x15 misses again.
- Write miss to 0x02, then read 0x02 -> the write goes to memory only; the read misses.
- Assert flush after fills, then read 0x15 -> read misses. Separately, drop rst_n while in MISS_RD -> mem_req=0 immediately; a later spurious mem_ack produces no cpu_ready.
